// File: rtl/alu_pkg.sv
// Shared opcode encoding and FSM state type for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the control unit and the sequential ALU.
interface seq_alu_if #(
    parameter int WIDTH = 8
) ();

    logic             START;
    logic [3:0]       SELECT;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic [WIDTH-1:0] RESULT;
    logic [WIDTH-1:0] RESULT_HI;
    logic             ZERO;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    modport master (
        output START, SELECT, DATA1, DATA2,
        input  RESULT, RESULT_HI, ZERO, BUSY, DONE, ERR
    );

    modport slave (
        input  START, SELECT, DATA1, DATA2,
        output RESULT, RESULT_HI, ZERO, BUSY, DONE, ERR
    );

endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
// o_done is high during the last iteration cycle; o_product is then the full
// product, so the parent captures it on the same edge that retires the last bit.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic                r_run;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_acc;
    logic [2*WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  w_acc_nxt;

    // Partial sum for the current multiplier bit
    always_comb begin
        w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    end

    assign o_done    = r_run && (r_cnt == LAST);
    assign o_product = w_acc_nxt;

    // Iteration control: only this part is reset, so a reset mid-run aborts cleanly
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
        end else if (r_run) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
                r_run <= 1'b0;
            end
        end
    end

    // Operand latch and shift/accumulate datapath (qualified by control, not reset)
    always_ff @(posedge i_clk) begin
        if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (r_run) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU between register file and write-back. Single-cycle ops
// complete on the edge that accepts START; MUL runs WIDTH cycles in the
// shift-add sub-module while BUSY stalls the control unit.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic     CLK,
    input  logic     RESET,
    seq_alu_if.slave bus
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                w_accept;
    logic                w_launch_mul;
    logic                w_mul_done;
    logic [2*WIDTH-1:0]  w_product;

    logic [SHW-1:0]      w_amt;
    logic [SHW-1:0]      w_rot;
    logic                w_amt_big;
    logic signed [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0]    w_res;
    logic                w_illegal;

    logic [WIDTH-1:0]    r_result;
    logic [WIDTH-1:0]    r_result_hi;
    logic                r_zero;
    logic                r_done;
    logic                r_err;

    // A request is only taken in IDLE; anything arriving during MUL_RUN is dropped
    assign w_accept     = bus.START && (r_state == IDLE);
    assign w_launch_mul = w_accept && (bus.SELECT == OP_MUL);

    assign w_amt     = bus.DATA2[SHW-1:0];
    assign w_amt_big = (w_amt >= SHW'(WIDTH));
    assign w_rot     = w_amt % SHW'(WIDTH);
    assign w_sra     = $signed(bus.DATA1) >>> w_amt;

    // Single-cycle result; out-of-range shifts saturate to 0 or sign fill
    always_comb begin
        w_res     = '0;
        w_illegal = 1'b0;
        case (bus.SELECT)
            OP_MOV: w_res = bus.DATA1;
            OP_ADD: w_res = bus.DATA1 + bus.DATA2;
            OP_AND: w_res = bus.DATA1 & bus.DATA2;
            OP_OR:  w_res = bus.DATA1 | bus.DATA2;
            OP_SRL: w_res = w_amt_big ? '0 : (bus.DATA1 >> w_amt);
            OP_SLL: w_res = w_amt_big ? '0 : (bus.DATA1 << w_amt);
            OP_ROR: w_res = (bus.DATA1 >> w_rot) | (bus.DATA1 << (SHW'(WIDTH) - w_rot));
            OP_SRA: w_res = w_amt_big ? {WIDTH{bus.DATA1[WIDTH-1]}} : w_sra;
            OP_MUL: w_res = '0;
            default: w_illegal = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave IDLE only for MUL, return when the last bit retires
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_launch_mul) w_state_nxt = MUL_RUN;
            MUL_RUN: if (w_mul_done)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    seq_multiplier #(
        .WIDTH(WIDTH)
    ) u_mul (
        .i_clk     (CLK),
        .i_rst_n   (RESET),
        .i_start   (w_launch_mul),
        .i_a       (bus.DATA1),
        .i_b       (bus.DATA2),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // Result registers: written only on completion, DONE pulses for one cycle
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == MUL_RUN) && w_mul_done) begin
                r_result    <= w_product[WIDTH-1:0];
                r_result_hi <= w_product[2*WIDTH-1:WIDTH];
                r_zero      <= (w_product == '0);
                r_err       <= 1'b0;
                r_done      <= 1'b1;
            end else if (w_accept && !w_launch_mul) begin
                r_result    <= w_res;
                r_result_hi <= '0;
                r_zero      <= (w_res == '0);
                r_err       <= w_illegal;
                r_done      <= 1'b1;
            end
        end
    end

    assign bus.RESULT    = r_result;
    assign bus.RESULT_HI = r_result_hi;
    assign bus.ZERO      = r_zero;
    assign bus.BUSY      = (r_state == MUL_RUN);
    assign bus.DONE      = r_done;
    assign bus.ERR       = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=8 and WIDTH=16.
module tb_seq_alu;
    import alu_pkg::*;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    seq_alu_if #(.WIDTH(8))  bus8 ();
    seq_alu_if #(.WIDTH(16)) bus16 ();

    seq_alu #(.WIDTH(8)) dut8 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus8.slave)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus16.slave)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [14] = '{
        '{OP_SRA, 8'h90, 8'h02, 8'hE4},
        '{OP_SRA, 8'h90, 8'h09, 8'hFF},
        '{OP_SRL, 8'h90, 8'h09, 8'h00},
        '{OP_ROR, 8'h81, 8'h09, 8'hC0},
        '{OP_ROR, 8'h81, 8'h08, 8'h81},
        '{OP_SLL, 8'h03, 8'h03, 8'h18},
        '{OP_SLL, 8'h81, 8'h08, 8'h00},
        '{OP_SRL, 8'h90, 8'h00, 8'h90},
        '{OP_SRA, 8'h70, 8'h02, 8'h1C},
        '{OP_SRA, 8'h90, 8'h00, 8'h90},
        '{OP_ADD, 8'h05, 8'hFB, 8'h00},
        '{OP_AND, 8'hF0, 8'h3C, 8'h30},
        '{OP_OR,  8'h0F, 8'h30, 8'h3F},
        '{OP_MOV, 8'h5A, 8'h00, 8'h5A}
    };

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic op8(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        bus8.START  = 1'b1;
        bus8.SELECT = sel;
        bus8.DATA1  = a;
        bus8.DATA2  = b;
        tick();
        bus8.START  = 1'b0;
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b, output int busy_cyc);
        op8(OP_MUL, a, b);
        busy_cyc = 0;
        while (bus8.BUSY && busy_cyc < 40) begin
            busy_cyc++;
            tick();
        end
    endtask

    task automatic check_reset8(input string tag);
        check_eq({tag, "_result"}, 32'(bus8.RESULT),    32'h0);
        check_eq({tag, "_hi"},     32'(bus8.RESULT_HI), 32'h0);
        check_eq({tag, "_zero"},   32'(bus8.ZERO),      32'h1);
        check_eq({tag, "_busy"},   32'(bus8.BUSY),      32'h0);
        check_eq({tag, "_done"},   32'(bus8.DONE),      32'h0);
        check_eq({tag, "_err"},    32'(bus8.ERR),       32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int saw_done;

        bus8.START   = 1'b0;
        bus8.SELECT  = 4'h0;
        bus8.DATA1   = '0;
        bus8.DATA2   = '0;
        bus16.START  = 1'b0;
        bus16.SELECT = 4'h0;
        bus16.DATA1  = '0;
        bus16.DATA2  = '0;

        RESET = 1'b0;
        tick();
        tick();
        check_reset8("rst");
        check_eq("rst16_busy", 32'(bus16.BUSY), 32'h0);
        RESET = 1'b1;
        tick();

        op8(OP_ADD, 8'h80, 8'h80);
        check_eq("add_result", 32'(bus8.RESULT), 32'h00);
        check_eq("add_zero",   32'(bus8.ZERO),   32'h1);
        check_eq("add_done",   32'(bus8.DONE),   32'h1);
        check_eq("add_busy",   32'(bus8.BUSY),   32'h0);
        check_eq("add_hi",     32'(bus8.RESULT_HI), 32'h0);
        tick();
        check_eq("add_done_fall", 32'(bus8.DONE), 32'h0);
        check_eq("add_busy2",     32'(bus8.BUSY), 32'h0);

        for (int i = 0; i < 14; i++) begin
            op8(vecs[i].sel, vecs[i].a, vecs[i].b);
            check_eq($sformatf("vec%0d_result", i), 32'(bus8.RESULT), 32'(vecs[i].exp));
            check_eq($sformatf("vec%0d_done", i),   32'(bus8.DONE),   32'h1);
            check_eq($sformatf("vec%0d_zero", i),   32'(bus8.ZERO),   32'(vecs[i].exp == 8'h00));
        end
        tick();

        mul8(8'd13, 8'd11, n);
        check_eq("mul13_busycyc", 32'(n),               32'd8);
        check_eq("mul13_done",    32'(bus8.DONE),      32'h1);
        check_eq("mul13_lo",      32'(bus8.RESULT),    32'h8F);
        check_eq("mul13_hi",      32'(bus8.RESULT_HI), 32'h00);
        check_eq("mul13_zero",    32'(bus8.ZERO),      32'h0);
        tick();
        check_eq("mul13_done_fall", 32'(bus8.DONE),   32'h0);
        check_eq("mul13_hold",      32'(bus8.RESULT), 32'h8F);

        mul8(8'hFF, 8'hFF, n);
        check_eq("mulff_lo", 32'(bus8.RESULT),    32'h01);
        check_eq("mulff_hi", 32'(bus8.RESULT_HI), 32'hFE);
        check_eq("mulff_done", 32'(bus8.DONE),    32'h1);
        tick();

        op8(OP_MUL, 8'd13, 8'd11);
        tick();
        tick();
        bus8.START  = 1'b1;
        bus8.SELECT = OP_ADD;
        bus8.DATA1  = 8'h01;
        bus8.DATA2  = 8'h01;
        tick();
        bus8.START  = 1'b0;
        bus8.DATA1  = 8'hA5;
        bus8.DATA2  = 8'h3C;
        n = 0;
        while (bus8.BUSY && n < 40) begin
            n++;
            tick();
        end
        check_eq("ignore_busycyc", 32'(n),               32'd5);
        check_eq("ignore_done",    32'(bus8.DONE),      32'h1);
        check_eq("ignore_lo",      32'(bus8.RESULT),    32'h8F);
        check_eq("ignore_hi",      32'(bus8.RESULT_HI), 32'h00);
        tick();
        check_eq("ignore_noqueue", 32'(bus8.DONE), 32'h0);

        mul8(8'd2, 8'd3, n);
        check_eq("b2b_mul_lo", 32'(bus8.RESULT), 32'h06);
        op8(OP_OR, 8'h0F, 8'hF0);
        check_eq("b2b_or_done",   32'(bus8.DONE),      32'h1);
        check_eq("b2b_or_result", 32'(bus8.RESULT),    32'hFF);
        check_eq("b2b_or_hi",     32'(bus8.RESULT_HI), 32'h00);
        tick();

        op8(OP_MUL, 8'h12, 8'h34);
        tick();
        tick();
        tick();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        check_reset8("midmul");
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.DONE) saw_done++;
        end
        check_eq("midmul_nodone", 32'(saw_done), 32'd0);

        mul8(8'd3, 8'd5, n);
        check_eq("mul35_busycyc", 32'(n),               32'd8);
        check_eq("mul35_lo",      32'(bus8.RESULT),    32'h0F);
        check_eq("mul35_hi",      32'(bus8.RESULT_HI), 32'h00);
        tick();

        op8(4'hF, 8'h12, 8'h34);
        check_eq("ill_err",    32'(bus8.ERR),       32'h1);
        check_eq("ill_result", 32'(bus8.RESULT),    32'h00);
        check_eq("ill_hi",     32'(bus8.RESULT_HI), 32'h00);
        check_eq("ill_zero",   32'(bus8.ZERO),      32'h1);
        check_eq("ill_done",   32'(bus8.DONE),      32'h1);
        op8(OP_MOV, 8'h5A, 8'h00);
        check_eq("mov_result", 32'(bus8.RESULT), 32'h5A);
        check_eq("mov_err",    32'(bus8.ERR),    32'h0);
        check_eq("mov_zero",   32'(bus8.ZERO),   32'h0);
        tick();

        bus16.START  = 1'b1;
        bus16.SELECT = OP_MUL;
        bus16.DATA1  = 16'hFFFF;
        bus16.DATA2  = 16'hFFFF;
        tick();
        bus16.START  = 1'b0;
        n = 0;
        while (bus16.BUSY && n < 60) begin
            n++;
            tick();
        end
        check_eq("mul16_busycyc", 32'(n),                32'd16);
        check_eq("mul16_done",    32'(bus16.DONE),      32'h1);
        check_eq("mul16_lo",      32'(bus16.RESULT),    32'h0001);
        check_eq("mul16_hi",      32'(bus16.RESULT_HI), 32'hFFFE);
        check_eq("mul16_zero",    32'(bus16.ZERO),      32'h0);
        tick();
        check_eq("mul16_done_fall", 32'(bus16.DONE), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
